// File: rtl/ascon_bdi_packer_pkg.sv
// Shared Ascon definitions: bdi data-type codes and the presented-word record.
package ascon_bdi_packer_pkg;

    localparam logic [3:0] D_NULL  = 4'h0;
    localparam logic [3:0] D_NONCE = 4'h1;
    localparam logic [3:0] D_AD    = 4'h2;
    localparam logic [3:0] D_MSG   = 4'h4;
    localparam logic [3:0] D_TAG   = 4'h8;
    localparam logic [3:0] D_HASH  = 4'h3;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
        logic [3:0]  dtype;
        logic        eot;
        logic        eoi;
    } bdi_word_t;

    // Right-aligned byte mask for a word whose highest filled lane is last_lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] last_lane);
        return 4'b1111 >> (2'd3 - last_lane);
    endfunction

endpackage

// File: rtl/ascon_bdi_packer.sv
// Packs an 8-bit segment stream into little-endian 32-bit bdi words,
// one word per segment boundary or per four bytes, through a one-entry output register.
module ascon_bdi_packer
    import ascon_bdi_packer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  s_type,
    input  logic        s_last,
    input  logic        s_final,
    output logic [31:0] bdi,
    output logic [3:0]  bdi_valid,
    input  logic        bdi_ready,
    output logic [3:0]  bdi_type,
    output logic        bdi_eot,
    output logic        bdi_eoi
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pack_q, pack_d;
    logic [3:0]  type_q, type_d;
    bdi_word_t   out_q, out_d;

    logic        out_full;
    logic        accept;
    logic [3:0]  word_type;
    logic [31:0] merged;

    assign out_full = (out_q.mask != 4'b0000);
    // Only a full register that the core is not draining this cycle blocks input.
    assign s_ready  = !(out_full && !bdi_ready);
    assign accept   = s_valid && s_ready;

    always_comb begin
        cnt_d     = cnt_q;
        pack_d    = pack_q;
        type_d    = type_q;
        out_d     = out_q;
        word_type = (cnt_q == 2'd0) ? s_type : type_q;
        // Unfilled lanes of pack_q are always zero, so OR-in places the byte.
        merged    = pack_q | (32'(s_data) << {cnt_q, 3'b000});

        if (out_full && bdi_ready) begin
            out_d       = '0;
            out_d.dtype = D_NULL;
        end

        if (accept) begin
            if (s_last || cnt_q == 2'd3) begin
                out_d.data  = merged;
                out_d.mask  = lane_mask(cnt_q);
                out_d.dtype = word_type;
                out_d.eot   = s_last;
                out_d.eoi   = s_last && s_final;
                cnt_d       = 2'd0;
                pack_d      = '0;
            end else begin
                pack_d = merged;
                cnt_d  = cnt_q + 2'd1;
                type_d = word_type;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= 2'd0;
            pack_q      <= '0;
            type_q      <= D_NULL;
            out_q       <= '0;
            out_q.dtype <= D_NULL;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
            type_q <= type_d;
            out_q  <= out_d;
        end
    end

    assign bdi       = out_q.data;
    assign bdi_valid = out_q.mask;
    assign bdi_type  = out_q.dtype;
    assign bdi_eot   = out_q.eot;
    assign bdi_eoi   = out_q.eoi;

endmodule

// File: doc/ascon_bdi_packer.md
ASCON_BDI_PACKER -- requirements
Module: ascon_bdi_packer
Upstream stage of the Ascon core. Packs a byte stream into 32-bit bdi words with byte-valid mask, type, eot and eoi.

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 s_data  in  8  input byte.
REQ-004 s_valid  in  1  s_data/s_type/s_last/s_final valid.
REQ-005 s_ready  out  1  packer accepts byte; transfer when s_valid & s_ready.
REQ-006 s_type  in  4  segment type (D_NONCE, D_AD, D_MSG, D_TAG).
REQ-007 s_last  in  1  byte is last of its segment.
REQ-008 s_final  in  1  segment is last of the instance; meaningful only with s_last.
REQ-009 bdi  out  32  packed word to core.
REQ-010 bdi_valid  out  4  byte-lane mask; 0 = no word presented.
REQ-011 bdi_ready  in  1  core accepts word; transfer when bdi_valid!=0 & bdi_ready.
REQ-012 bdi_type  out  4  type of presented word; D_NULL when empty.
REQ-013 bdi_eot  out  1  presented word ends its segment.
REQ-014 bdi_eoi  out  1  presented word ends the instance.

Function
REQ-015 Lane order SHALL be little-endian: 1st byte of a word -> bdi[7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
REQ-016 Masks SHALL be right-aligned: 4'b0001, 0011, 0111, 1111 only; invalid lanes SHALL be 0.
REQ-017 A 2-bit lane counter SHALL track bytes held in the packing register (0..3).
REQ-018 A word SHALL complete on acceptance of the 4th byte or of any byte with s_last=1, whichever comes first.
REQ-019 Bytes of different segments SHALL never share a word; after s_last the lane counter SHALL return to 0.
REQ-020 Word type SHALL be s_type sampled at its first byte; s_type changes within a word SHALL be ignored.
REQ-021 bdi_eot SHALL equal s_last of the completing byte; bdi_eoi SHALL equal s_last & s_final of that byte.
REQ-022 A completed word SHALL move into a one-entry output register; the output register drives bdi, bdi_valid, bdi_type, bdi_eot and bdi_eoi.
REQ-023 Latency: the word SHALL appear on bdi in the cycle after its completing byte is accepted.
REQ-024 Outputs SHALL remain stable while bdi_valid!=0 & !bdi_ready.
REQ-025 s_ready SHALL be !(out_full & !bdi_ready); combinational dependence on bdi_ready is permitted.
REQ-026 Simultaneous word completion and bdi handshake SHALL load the new word with no bubble.
REQ-027 Sustained throughput SHALL be 1 byte/cycle when bdi_ready is held high.
REQ-028 When the output register is empty: bdi_valid=0, bdi=0, bdi_type=D_NULL, bdi_eot=0, bdi_eoi=0.
REQ-029 Zero-length segments SHALL NOT be supported; an empty trailing segment is expressed by s_final on the last byte of the preceding segment.

Reset
REQ-030 On rst: lane counter 0, packing register cleared, output register empty, all outputs per REQ-028.
REQ-031 s_ready SHALL be 1 in the cycle after rst deasserts.
REQ-032 Reset mid-word SHALL discard partial bytes and any pending output word without emitting them.

Structure
REQ-033 Data type constants (D_NULL, D_NONCE, D_AD, D_MSG, D_TAG, D_HASH) SHALL come from the shared Ascon package; no local redefinition.
REQ-034 The design SHALL be a single module with no sub-modules.

Verification
REQ-035 AD bytes 0x00..0x07, s_last on 0x07, s_final=0 -> words 0x03020100 mask F eot0; 0x07060504 mask F eot1 eoi0.
REQ-036 MSG bytes 0x11..0x15, s_last & s_final on 0x15 -> 0x14131211 mask F; 0x00000015 mask 1 eot1 eoi1.
REQ-037 16 nonce bytes (last on 16th), then AD byte 0xAA last -> 4 nonce words, eot on 4th only; AD word 0x000000AA mask 1 type D_AD, no cross-segment merge.
REQ-038 bdi_ready low 10 cycles during a 12-byte stream -> s_ready drops after output fills; all 3 words delivered in order, no loss or duplication.
REQ-039 Output full, bdi_ready=1 in the same cycle as the completing byte -> next word valid next cycle; 1 word per 4 cycles sustained.
REQ-040 rst asserted after 2 of 4 bytes -> bdi_valid=0 next cycle; the following byte lands in bdi[7:0].
